latency_memory: RTL and testbench
=================================

# latency_memory

Parametrised single-port data/instruction memory for the multicycle CPU with a configurable access latency and a request/ready handshake. Replaces the fixed 32×8 zero-latency array so the controller can be exercised against slower memories. Sits between the datapath address/write-data mux and the IR/MDR registers. One access is outstanding at a time.

## Interface

- DATA_W, 8, word width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W words
- READ_LAT, 1, cycles from read acceptance to data valid; legal range 1..15
- WRITE_LAT, 1, cycles from write acceptance to commit; legal range 1..15

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- address  input  ADDR_W  word address, sampled at acceptance
- writeData  input  DATA_W  write data, sampled at acceptance
- memRead  input  1  read request
- memWrite  input  1  write request
- out  output  DATA_W  registered read data; holds the last completed read
- ready  output  1  one-cycle completion pulse, for both reads and writes
- busy  output  1  high while an access is in flight

## Operation

- State machine states: IDLE and BUSY.
- IDLE: a request is accepted at a rising edge where memRead or memWrite is high. At that edge the block latches address, writeData, and the op, loads cnt = LAT−1 for the op, and moves to BUSY.
- If memRead and memWrite are both high, the request is a write; the read is dropped.
- BUSY: requests are ignored and memRead/memWrite/address/writeData may change freely. Each edge with cnt≠0 decrements cnt. At the edge where cnt==0:
  - read: out ← mem[latched addr]
  - write: mem[latched addr] ← latched data; out is unchanged
  - in both cases ready←1 and the state returns to IDLE.
- ready is high for exactly one cycle. In that cycle the block is IDLE, and a request presented then is accepted at the next edge.
- Array contents are not initialised or cleared by rst. The initial program image is preloaded by the testbench or an initial block.
- Address wrap: none needed, because the address width equals the depth.

## Timing

- Reset values: out=0, ready=0, busy=0, state=IDLE, cnt=0.
- Accept at edge k. The access completes at edge k+LAT, and ready is high in the cycle after edge k+LAT.
- A read issued at edge k has valid data on out from edge k+LAT onward, held until the next read completes.
- busy is high from edge k to edge k+LAT; it is low in the ready cycle.
- Maximum throughput is one access per LAT+1 cycles.
- Read-after-write to the same address returns the new data, because the write commits before the read can be accepted.
- rst asserted mid-access:
  - the access is aborted at that edge and a pending write is not committed
  - out, ready, busy and state all go to their reset values
  - a request held high during rst is not accepted until the first edge with rst low.

## Test plan

- Reset then idle, defaults: out=0, ready=0, busy=0, and they stay there with no requests.
- Preload mem[29]=8'h08; READ_LAT=3; read addr 29 at edge 0. Required: busy high edges 0–3, out=8'h08 and ready=1 after edge 3, ready=0 after edge 4.
- WRITE_LAT=2; write 8'hBB to addr 31, then immediately read addr 31 in the ready cycle. Required: the read returns 8'hBB and out is unchanged during the write.
- memRead and memWrite both high, addr 30, data 8'h10, old contents 8'h55. Required: the request is treated as a write, out is not updated, and a later read of addr 30 returns 8'h10.
- Toggle address and writeData every cycle while BUSY. Required: only the values latched at acceptance are used, and the extra requests raised while busy are ignored.
- WRITE_LAT=4; write 8'hAA to addr 2 and assert rst at edge 2. Required: mem[2] keeps its old value, and outputs read 0/0/0 at the next edge.

Source files
------------

// File: rtl/latency_memory.sv
// Single-port memory with configurable read/write latency and a request/ready handshake.
// One access in flight at a time; ready pulses for one cycle when the access completes.
module latency_memory #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int READ_LAT  = 1,
    parameter int WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              memRead,
    input  logic              memWrite,
    output logic [DATA_W-1:0] out,
    output logic              ready,
    output logic              busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] RD_LOAD = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LAT - 1);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [0:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_is_wr;
    logic [DATA_W-1:0] r_out;
    logic              r_ready;

    logic w_done;
    logic w_commit_wr;

    assign w_done      = (r_state == S_BUSY) && (r_cnt == 4'd0);
    // A reset on the commit edge aborts the write.
    assign w_commit_wr = !rst && w_done && r_is_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_data  <= '0;
            r_is_wr <= 1'b0;
            r_out   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (memRead || memWrite) begin
                        r_addr  <= address;
                        r_data  <= writeData;
                        r_is_wr <= memWrite;
                        r_cnt   <= memWrite ? WR_LOAD : RD_LOAD;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_is_wr) begin
                            r_out <= r_mem[r_addr];
                        end
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Array kept out of the reset domain so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign out   = r_out;
    assign ready = r_ready;
    assign busy  = (r_state == S_BUSY);

endmodule

// File: tb/tb_latency_memory.sv
// Scoreboard bench for latency_memory: expected read data is queued at issue and
// compared when ready pulses; handshake timing is checked cycle by cycle.
module tb_latency_memory;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 5;
    localparam int READ_LAT  = 3;
    localparam int WRITE_LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] out;
    logic              ready;
    logic              busy;

    logic [DATA_W-1:0] model [2**ADDR_W];
    logic [DATA_W-1:0] exp_q [$];
    int n_total = 0;
    int n_bad   = 0;

    latency_memory #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT),
        .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .writeData(writeData),
        .memRead  (memRead),
        .memWrite (memWrite),
        .out      (out),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request at the next negedge; it is accepted at the following edge.
    task automatic access(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input bit toggle);
        logic [DATA_W-1:0] prev_out;
        int lat;
        @(negedge clk);
        memRead   = rd;
        memWrite  = wr;
        address   = a;
        writeData = d;
        prev_out  = out;
        lat       = wr ? WRITE_LAT : READ_LAT;
        if (!wr) exp_q.push_back(model[a]);
        @(posedge clk);
        for (int i = 0; i < lat; i++) begin
            #1;
            check("busy_in_flight", 32'(busy), 32'd1);
            check("ready_in_flight", 32'(ready), 32'd0);
            check("out_held", 32'(out), 32'(prev_out));
            @(negedge clk);
            if (toggle) begin
                memRead   = 1'b1;
                memWrite  = 1'($urandom_range(0, 1));
                address   = ADDR_W'($urandom);
                writeData = DATA_W'($urandom);
            end else begin
                memRead  = 1'b0;
                memWrite = 1'b0;
            end
            @(posedge clk);
        end
        #1;
        check("ready_pulse", 32'(ready), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        if (wr) begin
            model[a] = d;
            check("out_after_write", 32'(out), 32'(prev_out));
        end else if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            check("read_data", 32'(out), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        logic [DATA_W-1:0] held;
        held = out;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            memRead  = 1'b0;
            memWrite = 1'b0;
            @(posedge clk);
            #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready", 32'(ready), 32'd0);
            check("idle_out", 32'(out), 32'(held));
        end
    endtask

    initial begin
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; writeData = '0;
        for (int i = 0; i < 2**ADDR_W; i++) model[i] = 'x;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;
        idle(3);
        check("idle_out_zero", 32'(out), 32'd0);

        // Preload then read with READ_LAT
        access(1'b0, 1'b1, 5'd29, 8'h08, 1'b0);
        access(1'b1, 1'b0, 5'd29, 8'h00, 1'b0);
        @(negedge clk); memRead = 1'b0; memWrite = 1'b0;
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(ready), 32'd0);
        check("out_held_after", 32'(out), 32'h08);

        // Read in the ready cycle of a write sees the new data
        access(1'b0, 1'b1, 5'd31, 8'hBB, 1'b0);
        access(1'b1, 1'b0, 5'd31, 8'h00, 1'b0);

        // Simultaneous read+write behaves as a write
        access(1'b0, 1'b1, 5'd30, 8'h55, 1'b0);
        access(1'b1, 1'b1, 5'd30, 8'h10, 1'b0);
        access(1'b1, 1'b0, 5'd30, 8'h00, 1'b0);
        check("rw_conflict_data", 32'(out), 32'h10);

        // Inputs churn while busy; only the accepted values matter
        access(1'b0, 1'b1, 5'd5, 8'h77, 1'b1);
        access(1'b1, 1'b0, 5'd5, 8'h00, 1'b1);
        check("toggle_read", 32'(out), 32'h77);
        access(1'b1, 1'b0, 5'd31, 8'h00, 1'b1);
        idle(2);

        // Reset in the middle of a write aborts it
        access(1'b0, 1'b1, 5'd2, 8'h3C, 1'b0);
        @(negedge clk); memWrite = 1'b1; memRead = 1'b0; address = 5'd2; writeData = 8'hAA;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd1);
        @(negedge clk); memWrite = 1'b0; memRead = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out", 32'(out), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("held_req_in_rst", 32'(busy), 32'd0);
        rst = 1'b0;
        access(1'b1, 1'b0, 5'd2, 8'h00, 1'b0);
        check("abort_kept_old", 32'(out), 32'h3C);

        // Random write/read pairs
        for (int k = 0; k < 6; k++) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            a = ADDR_W'($urandom);
            d = DATA_W'($urandom);
            access(1'b0, 1'b1, a, d, 1'b0);
            access(1'b1, 1'b0, a, 8'h00, 1'b0);
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
